// File: rtl/vmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmem_arb_pkg
// Brief    : Shared types and constants for the video-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vmem_arb_pkg;

  localparam int c_DEF_AW = 19;
  localparam int c_DEF_DW = 24;

  // Round-robin pointer encoding: which writer wins a tie.
  localparam logic c_RR_WR0 = 1'b0;
  localparam logic c_RR_WR1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    WR0  = 2'd2,
    WR1  = 2'd3
  } arb_state_t;

  function automatic arb_state_t wr_state(input logic sel);
    return (sel == c_RR_WR1) ? WR1 : WR0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vmem_port_arbiter_if
// Brief    : Scanout, writer and memory-port signals of the vmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vmem_port_arbiter_if
  import vmem_arb_pkg::*;
#(
  parameter int AW = c_DEF_AW,
  parameter int DW = c_DEF_DW
) ();

  logic          disp_pre;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;

  logic          wr0_req;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr0_last;
  logic          wr0_gnt;

  logic          wr1_req;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          wr1_last;
  logic          wr1_gnt;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Requester/environment side: scanout, writers and the memory model.
  modport master (
    output disp_pre, disp_addr,
    output wr0_req, wr0_addr, wr0_data, wr0_last,
    output wr1_req, wr1_addr, wr1_data, wr1_last,
    output mem_rdata,
    input  disp_data, wr0_gnt, wr1_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  disp_pre, disp_addr,
    input  wr0_req, wr0_addr, wr0_data, wr0_last,
    input  wr1_req, wr1_addr, wr1_data, wr1_last,
    input  mem_rdata,
    output disp_data, wr0_gnt, wr1_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/vmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : vmem_rr_pick
// Brief    : Combinational 2-way round-robin picker (ptr breaks ties).
// Revision : 1.0 - initial release
// ============================================================================
module vmem_rr_pick
  import vmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
    sel   = ptr;
    if (req == 2'b01) begin
      sel = c_RR_WR0;
    end else if (req == 2'b10) begin
      sel = c_RR_WR1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vmem_port_arbiter
// Brief    : Shares the single-port frame store between scanout (priority) and
//            two round-robin writers. Optional VMEM_ARB_STALL_CNT_EN adds
//            per-writer saturating stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_port_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int DW        = c_DEF_DW,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  vmem_port_arbiter_if.slave  bus
`ifdef VMEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]         wr0_stall_cnt,
  output logic [15:0]         wr1_stall_cnt
`endif
);

  localparam int            c_BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_BW-1:0] c_BEAT_MAX = c_BW'(MAX_BURST - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_rr_ptr;
  logic             w_rr_ptr_nxt;
  logic [c_BW-1:0]  r_beat;
  logic [c_BW-1:0]  w_beat_nxt;
  logic             r_rd_pend;
  logic [DW-1:0]    r_disp_data;

  logic [1:0]       w_req;
  logic             w_in_wr;
  logic             w_cur_wr;
  logic             w_cur_req;
  logic             w_cur_last;
  logic             w_burst_done;
  logic             w_pick_valid;
  logic             w_pick_sel;

  assign w_req        = {bus.wr1_req, bus.wr0_req};
  assign w_in_wr      = (r_state == WR0) || (r_state == WR1);
  assign w_cur_wr     = (r_state == WR1);
  assign w_cur_req    = w_cur_wr ? bus.wr1_req  : bus.wr0_req;
  assign w_cur_last   = w_cur_wr ? bus.wr1_last : bus.wr0_last;
  assign w_burst_done = w_in_wr && w_cur_req && (w_cur_last || (r_beat == c_BEAT_MAX));

  vmem_rr_pick u_pick (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .sel   (w_pick_sel)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    if (bus.disp_pre) begin
      w_state_nxt = DISP;
      // A preempted writer keeps the tie-break so it resumes first after blanking.
      if (w_in_wr) begin
        w_rr_ptr_nxt = w_burst_done ? ~w_cur_wr : w_cur_wr;
      end
    end else if (!w_in_wr) begin
      w_state_nxt = w_pick_valid ? wr_state(w_pick_sel) : IDLE;
    end else if (w_burst_done) begin
      w_state_nxt  = IDLE;
      w_rr_ptr_nxt = ~w_cur_wr;
    end else if (!w_cur_req) begin
      w_state_nxt = IDLE;
    end

    w_beat_nxt = r_beat;
    if (w_state_nxt != r_state) begin
      w_beat_nxt = '0;
    end else if (w_in_wr && w_cur_req) begin
      w_beat_nxt = r_beat + c_BW'(1);
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      DISP: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end
      WR0: begin
        bus.mem_en    = bus.wr0_req;
        bus.mem_we    = bus.wr0_req;
        bus.mem_addr  = bus.wr0_addr;
        bus.mem_wdata = bus.wr0_data;
      end
      WR1: begin
        bus.mem_en    = bus.wr1_req;
        bus.mem_we    = bus.wr1_req;
        bus.mem_addr  = bus.wr1_addr;
        bus.mem_wdata = bus.wr1_data;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  assign bus.wr0_gnt   = (r_state == WR0);
  assign bus.wr1_gnt   = (r_state == WR1);
  assign bus.disp_data = r_disp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= c_RR_WR0;
      r_beat      <= '0;
      r_rd_pend   <= 1'b0;
      r_disp_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_beat    <= w_beat_nxt;
      // Read data returns one cycle after a DISP access; only those update the pixel.
      r_rd_pend <= (r_state == DISP);
      if (r_rd_pend) begin
        r_disp_data <= bus.mem_rdata;
      end
    end
  end

`ifdef VMEM_ARB_STALL_CNT_EN
  logic [1:0] w_gnt;
  assign w_gnt = {r_state == WR1, r_state == WR0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stall
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_req[gi] && !w_gnt[gi] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign wr0_stall_cnt = g_stall[0].r_cnt;
  assign wr1_stall_cnt = g_stall[1].r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmem_port_arbiter
// Brief    : Self-checking bench for vmem_port_arbiter (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vmem_port_arbiter;
  import vmem_arb_pkg::*;

  localparam int AW        = 19;
  localparam int DW        = 24;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef VMEM_ARB_STALL_CNT_EN
  logic [15:0] wr0_stall_cnt;
  logic [15:0] wr1_stall_cnt;
`endif

  vmem_port_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef VMEM_ARB_STALL_CNT_EN
    ,
    .wr0_stall_cnt (wr0_stall_cnt),
    .wr1_stall_cnt (wr1_stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame store: sparse, 1-cycle synchronous read.
  logic [DW-1:0] tbmem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return tbmem.exists(a) ? tbmem[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tbmem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= mem_rd(bus.mem_addr);
    end
  end

  // Writer agents
  int            w_left [2];
  int            w_sent [2];
  int            w_blen [2];
  logic          w_hold [2];
  logic [AW-1:0] w_base [2];

  // Values sampled mid-cycle by cyc()
  logic          s_g0, s_g1, s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_disp;
  int            q_acc  [$];
  logic [AW-1:0] q_addr [$];

  function automatic logic wr_last(input int n);
    return (w_blen[n] > 0) && (((w_sent[n] + 1) % w_blen[n]) == 0);
  endfunction

  task automatic drive_writers();
    bus.wr0_req  = (w_left[0] > 0) && !w_hold[0];
    bus.wr0_addr = w_base[0] + AW'(w_sent[0]);
    bus.wr0_data = 24'hA00000 + DW'(w_sent[0]);
    bus.wr0_last = wr_last(0);
    bus.wr1_req  = (w_left[1] > 0) && !w_hold[1];
    bus.wr1_addr = w_base[1] + AW'(w_sent[1]);
    bus.wr1_data = 24'hB00000 + DW'(w_sent[1]);
    bus.wr1_last = wr_last(1);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input logic dp);
    bus.disp_pre = dp;
    drive_writers();
    #1;
    s_g0 = bus.wr0_gnt;   s_g1 = bus.wr1_gnt;
    s_en = bus.mem_en;    s_we = bus.mem_we;
    s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_disp = bus.disp_data;
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if ((n == 0 ? s_g0 : s_g1) && (n == 0 ? bus.wr0_req : bus.wr1_req)) begin
        q_acc.push_back(n);
        q_addr.push_back(s_addr);
        w_sent[n]++;
        w_left[n]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_agents();
    for (int n = 0; n < 2; n++) begin
      w_left[n] = 0; w_sent[n] = 0; w_blen[n] = 0; w_hold[n] = 1'b0; w_base[n] = '0;
    end
    bus.disp_pre = 1'b0;
    bus.disp_addr = '0;
    drive_writers();
    q_acc.delete();
    q_addr.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_agents();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_agents();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.wr0_gnt, bus.wr1_gnt, bus.mem_en, bus.mem_we} !== 4'b0000 || bus.disp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt0/gnt1/en/we=%b disp=%h, required 0000 and 0",
               {bus.wr0_gnt, bus.wr1_gnt, bus.mem_en, bus.mem_we}, bus.disp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      n_tests++;
      if ({s_g0, s_g1, s_en, s_we} !== 4'b0000 || s_disp !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: cycle %0d gnt0/gnt1/en/we=%b disp=%h, required 0000 and 0",
                 i, {s_g0, s_g1, s_en, s_we}, s_disp);
      end
    end
  endtask

  task automatic test_scanout();
    apply_reset();
    tbmem[19'h00010] = 24'hFF0000;
    bus.disp_addr = 19'h00010;
    cyc(1'b1);
    n_tests++;
    if (s_en !== 1'b0) begin
      n_fail++; $display("FAIL scan_early: mem_en=%b, required 0 in the disp_pre cycle", s_en);
    end
    cyc(1'b0);
    n_tests++;
    if (s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 19'h00010) begin
      n_fail++;
      $display("FAIL scan_port: en=%b we=%b addr=%h, required 1 0 00010", s_en, s_we, s_addr);
    end
    cyc(1'b0);
    n_tests++;
    if (s_disp !== 24'h000000) begin
      n_fail++; $display("FAIL scan_t1: disp_data=%h, required 000000", s_disp);
    end
    tbmem[19'h00010] = 24'h123456;
    cyc(1'b0);
    n_tests++;
    if (s_disp !== 24'hFF0000) begin
      n_fail++; $display("FAIL scan_t2: disp_data=%h, required ff0000", s_disp);
    end
    cyc(1'b0);
    n_tests++;
    if (s_disp !== 24'hFF0000) begin
      n_fail++; $display("FAIL scan_hold: disp_data=%h, required ff0000", s_disp);
    end
  endtask

  task automatic test_round_robin();
    int exp_own [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int exp_addr [9] = '{'h100, 'h101, 'h102, 'h200, 'h201, 'h202, 'h103, 'h104, 'h105};
    apply_reset();
    w_left[0] = 6; w_blen[0] = 3; w_base[0] = 19'h100;
    w_left[1] = 3; w_blen[1] = 3; w_base[1] = 19'h200;
    for (int i = 0; i < 60 && (w_left[0] + w_left[1]) > 0; i++) cyc(1'b0);
    n_tests++;
    if (q_acc.size() != 9) begin
      n_fail++; $display("FAIL rr_beats: accepted %0d beats, required 9", q_acc.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (q_acc[i] != exp_own[i] || q_addr[i] !== AW'(exp_addr[i])) begin
          n_fail++;
          $display("FAIL rr_order: beat %0d writer %0d addr %h, required writer %0d addr %h",
                   i, q_acc[i], q_addr[i], exp_own[i], AW'(exp_addr[i]));
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    int ph = 0, run1 = 0, gap = 0, run2 = 0;
    apply_reset();
    w_left[1] = 20; w_blen[1] = 0; w_base[1] = 19'h040;
    for (int i = 0; i < 80 && w_left[1] > 0; i++) begin
      cyc(1'b0);
      case (ph)
        0: if (s_g1) begin ph = 1; run1 = 1; end
        1: if (s_g1) run1++; else begin ph = 2; gap = 1; end
        2: if (s_g1) begin ph = 3; run2 = 1; end else gap++;
        default: if (s_g1) run2++;
      endcase
    end
    n_tests++;
    if (run1 != MAX_BURST || gap != 1 || run2 != 4 || w_left[1] != 0) begin
      n_fail++;
      $display("FAIL burst_limit: run1=%0d gap=%0d run2=%0d left=%0d, required 16 1 4 0",
               run1, gap, run2, w_left[1]);
    end
  endtask

  task automatic test_preemption();
    int  pre = 0;
    bit  fired = 0;
    apply_reset();
    bus.disp_addr = 19'h00010;
    w_left[0] = 10; w_blen[0] = 10; w_base[0] = 19'h300;
    w_left[1] = 2;  w_blen[1] = 2;  w_base[1] = 19'h400;
    for (int i = 0; i < 80 && (w_left[0] + w_left[1]) > 0; i++) begin
      cyc(pre > 0);
      if (pre == 3) begin
        n_tests++;
        if (s_g0 !== 1'b1 || s_we !== 1'b1 || s_addr !== 19'h304) begin
          n_fail++;
          $display("FAIL preempt_beat5: gnt0=%b we=%b addr=%h, required 1 1 00304", s_g0, s_we, s_addr);
        end
      end else if (pre == 2) begin
        n_tests++;
        if (s_g0 !== 1'b0 || s_g1 !== 1'b0 || s_en !== 1'b1 || s_we !== 1'b0) begin
          n_fail++;
          $display("FAIL preempt_disp: gnt0=%b gnt1=%b en=%b we=%b, required 0 0 1 0", s_g0, s_g1, s_en, s_we);
        end
      end
      if (pre > 0) pre--;
      else if (!fired && s_g0 && w_sent[0] == 4) begin pre = 3; fired = 1; end
    end
    n_tests++;
    if (q_acc.size() != 12) begin
      n_fail++; $display("FAIL preempt_beats: accepted %0d, required 12", q_acc.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (q_acc[i] != (i < 10 ? 0 : 1)) begin
          n_fail++;
          $display("FAIL preempt_order: beat %0d writer %0d, required %0d", i, q_acc[i], (i < 10 ? 0 : 1));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    tbmem[19'h00020] = 24'h5A5A5A;
    bus.disp_addr = 19'h00020;
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    n_tests++;
    if (s_disp !== 24'h5A5A5A) begin
      n_fail++; $display("FAIL midrst_pre: disp_data=%h, required 5a5a5a", s_disp);
    end
    w_left[0] = 8; w_blen[0] = 8; w_base[0] = 19'h500;
    for (int i = 0; i < 20 && w_sent[0] < 3; i++) cyc(1'b0);
    drive_writers();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.wr0_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.disp_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: gnt0=%b en=%b disp=%h, required 0 0 0", bus.wr0_gnt, bus.mem_en, bus.disp_data);
    end
    @(negedge clk);
    n_tests++;
    if (mem_rd(19'h500) !== 24'hA00000 || mem_rd(19'h502) !== 24'hA00002 || tbmem.exists(19'h503)) begin
      n_fail++;
      $display("FAIL midrst_mem: mem[500]=%h mem[502]=%h beat4_written=%0d, required a00000 a00002 0",
               mem_rd(19'h500), mem_rd(19'h502), tbmem.exists(19'h503));
    end
    apply_reset();
  endtask

  task automatic test_random();
    int   m_owner = 3, m_ptr = 0, m_beats = 0;   // owner: 0/1 writer, 2 scanout, 3 idle
    bit   m_pend = 0;
    logic [DW-1:0] m_pend_data = '0, m_disp = '0;
    int   dp_run = 0;
    bit   dp_val = 0;
    logic mreq [2], mlast [2];
    logic e_en, e_we;
    logic [AW-1:0] e_addr;
    bit   fin;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (w_left[n] == 0 && $urandom_range(0, 3) == 0) begin
          w_left[n] = $urandom_range(1, 24);
          w_sent[n] = 0;
          w_base[n] = AW'($urandom);
          w_blen[n] = ($urandom_range(0, 2) == 0) ? 0 : w_left[n];
        end
        w_hold[n] = ($urandom_range(0, 9) == 0);
      end
      if (dp_run == 0) begin dp_val = !dp_val; dp_run = $urandom_range(1, 12); end
      dp_run--;
      bus.disp_addr = AW'($urandom);
      if ($urandom_range(0, 1) == 1) tbmem[bus.disp_addr] = DW'($urandom);
      cyc(dp_val);

      mreq[0] = bus.wr0_req;  mreq[1] = bus.wr1_req;
      mlast[0] = bus.wr0_last; mlast[1] = bus.wr1_last;
      e_en   = (m_owner == 2) || (m_owner < 2 && mreq[m_owner]);
      e_we   = (m_owner < 2) && mreq[m_owner];
      e_addr = (m_owner == 2) ? bus.disp_addr : (m_owner == 0) ? bus.wr0_addr : bus.wr1_addr;
      n_tests++;
      if (s_g0 !== (m_owner == 0) || s_g1 !== (m_owner == 1) || s_en !== e_en || s_we !== e_we ||
          (e_en && s_addr !== e_addr) ||
          (e_we && s_wdata !== ((m_owner == 0) ? bus.wr0_data : bus.wr1_data)) ||
          s_disp !== m_disp) begin
        n_fail++;
        $display("FAIL random: cycle %0d gnt=%b%b en=%b we=%b addr=%h disp=%h, required gnt=%b%b en=%b we=%b addr=%h disp=%h",
                 c, s_g1, s_g0, s_en, s_we, s_addr, s_disp,
                 (m_owner == 1), (m_owner == 0), e_en, e_we, e_addr, m_disp);
      end

      if (m_pend) m_disp = m_pend_data;
      m_pend = (m_owner == 2);
      m_pend_data = mem_rd(bus.disp_addr);
      if (bus.disp_pre) begin
        if (m_owner < 2) begin
          fin = mreq[m_owner] && (mlast[m_owner] || m_beats + 1 == MAX_BURST);
          m_ptr = fin ? 1 - m_owner : m_owner;
        end
        m_owner = 2; m_beats = 0;
      end else if (m_owner >= 2) begin
        if (mreq[0] && mreq[1]) m_owner = m_ptr;
        else if (mreq[0])       m_owner = 0;
        else if (mreq[1])       m_owner = 1;
        else                    m_owner = 3;
        m_beats = 0;
      end else if (!mreq[m_owner]) begin
        m_owner = 3; m_beats = 0;
      end else if (mlast[m_owner] || m_beats + 1 == MAX_BURST) begin
        m_ptr = 1 - m_owner; m_owner = 3; m_beats = 0;
      end else begin
        m_beats++;
      end
    end
  endtask

`ifdef VMEM_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    w_left[1] = 1; w_base[1] = 19'h600;
    for (int i = 0; i < 10; i++) cyc(1'b1);
    n_tests++;
    if (wr1_stall_cnt !== 16'd10 || wr0_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stall_early: wr1=%0d wr0=%0d, required 10 0", wr1_stall_cnt, wr0_stall_cnt);
    end
    for (int i = 0; i < 70000; i++) cyc(1'b1);
    n_tests++;
    if (wr1_stall_cnt !== 16'hFFFF || wr0_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stall_sat: wr1=%h wr0=%h, required ffff 0000", wr1_stall_cnt, wr0_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scanout();
    test_round_robin();
    test_burst_limit();
    test_preemption();
    test_mid_reset();
    test_random();
`ifdef VMEM_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
